// File: rtl/display_frame_loader_pkg.sv
// Shared display definitions: loader state encoding and default panel geometry
// used by the loader, the display driver and the double-buffered memory.
package display_frame_loader_pkg;

  localparam int DISP_ROWS    = 8;
  localparam int DISP_COLUMNS = 32;
  localparam int DISP_WIDTH   = 24;
  localparam int DISP_ROWBITS = $clog2(DISP_ROWS);
  localparam int DISP_COLBITS = $clog2(DISP_COLUMNS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_FLIP = 2'd2
  } state_t;

endpackage

// File: rtl/display_raster_counter.sv
// Row/column raster counter with clear, advance and explicit wrap.
// clear and advance together land on the pixel after (0,0).
module display_raster_counter #(
  parameter int ROWS    = 8,
  parameter int COLUMNS = 32,
  parameter int ROWBITS = $clog2(ROWS),
  parameter int COLBITS = $clog2(COLUMNS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  output logic [ROWBITS-1:0] row,
  output logic [COLBITS-1:0] col,
  output logic               last
);

  localparam logic [ROWBITS-1:0] ROW_MAX = ROWBITS'(ROWS - 1);
  localparam logic [COLBITS-1:0] COL_MAX = COLBITS'(COLUMNS - 1);

  logic [ROWBITS-1:0] base_row, row_n;
  logic [COLBITS-1:0] base_col, col_n;

  always_comb begin
    base_row = clear ? '0 : row;
    base_col = clear ? '0 : col;
    row_n    = base_row;
    col_n    = base_col;
    if (advance) begin
      // compare-and-clear so non-power-of-two geometries wrap correctly
      if (base_col == COL_MAX) begin
        col_n = '0;
        row_n = (base_row == ROW_MAX) ? '0 : base_row + ROWBITS'(1);
      end else begin
        col_n = base_col + COLBITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_n;
      col <= col_n;
    end
  end

  assign last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/display_frame_loader.sv
// Writes a host pixel stream into the display back buffer in raster order and
// swaps buffers on the driver's frame boundary once a full frame has landed.
module display_frame_loader
  import display_frame_loader_pkg::*;
#(
  parameter int ROWS    = DISP_ROWS,
  parameter int COLUMNS = DISP_COLUMNS,
  parameter int WIDTH   = DISP_WIDTH,
  parameter int ROWBITS = $clog2(ROWS),
  parameter int COLBITS = $clog2(COLUMNS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_sof,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               frame_end,
  output logic               mem_wen,
  output logic [ROWBITS-1:0] mem_wrow,
  output logic [COLBITS-1:0] mem_wcol,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic               mem_flip,
  output logic               busy,
  output logic               sync_err,
  output logic [7:0]         flip_count
);

  localparam bit FIRST_IS_LAST = (ROWS * COLUMNS == 1);

  state_t             state, state_n;
  logic               accept;
  logic               do_write, do_flip, set_err;
  logic               cnt_clear, cnt_adv, cnt_last, wr_last;
  logic [ROWBITS-1:0] cnt_row, wr_row;
  logic [COLBITS-1:0] cnt_col, wr_col;

  assign s_ready = (state != WAIT_FLIP);
  assign busy    = (state != IDLE);
  assign accept  = s_valid & s_ready;

  display_raster_counter #(
    .ROWS(ROWS), .COLUMNS(COLUMNS), .ROWBITS(ROWBITS), .COLBITS(COLBITS)
  ) u_cnt (
    .clk(clk), .rst(rst), .clear(cnt_clear), .advance(cnt_adv),
    .row(cnt_row), .col(cnt_col), .last(cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    do_write  = 1'b0;
    do_flip   = 1'b0;
    set_err   = 1'b0;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    wr_row    = cnt_row;
    wr_col    = cnt_col;
    wr_last   = cnt_last;
    case (state)
      IDLE: begin
        // beats before a start-of-frame are dropped
        if (accept && s_sof) begin
          do_write  = 1'b1;
          cnt_clear = 1'b1;
          cnt_adv   = 1'b1;
          wr_row    = '0;
          wr_col    = '0;
          wr_last   = FIRST_IS_LAST;
          state_n   = wr_last ? WAIT_FLIP : WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          do_write = 1'b1;
          cnt_adv  = 1'b1;
          if (s_sof) begin
            set_err   = 1'b1;
            cnt_clear = 1'b1;
            wr_row    = '0;
            wr_col    = '0;
            wr_last   = FIRST_IS_LAST;
          end
          state_n = wr_last ? WAIT_FLIP : WRITE;
        end
      end
      WAIT_FLIP: begin
        // frame_end is only looked at here, so a pulse coincident with the
        // last write is ignored and the swap waits for the next boundary
        if (frame_end) begin
          do_flip = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wen    <= 1'b0;
      mem_wrow   <= '0;
      mem_wcol   <= '0;
      mem_wdata  <= '0;
      mem_flip   <= 1'b0;
      sync_err   <= 1'b0;
      flip_count <= 8'd0;
    end else begin
      mem_wen <= do_write;
      if (do_write) begin
        mem_wrow  <= wr_row;
        mem_wcol  <= wr_col;
        mem_wdata <= s_data;
      end
      if (do_flip) begin
        mem_flip   <= ~mem_flip;
        flip_count <= flip_count + 8'd1;
      end
      if (set_err) sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_frame_loader.sv
// Directed-sequence bench with randomized pixel data and gaps, checked every
// cycle against a frame-level model (pixel index, waiting flag, flip level).
module tb_display_frame_loader;

  localparam int ROWS = 8, COLS = 32, W = 24, NPIX = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0, s_sof = 1'b0, frame_end = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, mem_wen, mem_flip, busy, sync_err;
  logic [2:0]    mem_wrow;
  logic [4:0]    mem_wcol;
  logic [W-1:0]  mem_wdata;
  logic [7:0]    flip_count;

  int checks = 0, errors = 0;

  // reference model
  bit       m_inframe, m_wait, m_err, m_flip;
  int       m_next, m_cnt;
  bit       e_wen;
  int       e_row, e_col;
  logic [W-1:0] e_data;

  display_frame_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_data(s_data), .frame_end(frame_end), .mem_wen(mem_wen),
    .mem_wrow(mem_wrow), .mem_wcol(mem_wcol), .mem_wdata(mem_wdata),
    .mem_flip(mem_flip), .busy(busy), .sync_err(sync_err), .flip_count(flip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inframe = 0; m_wait = 0; m_err = 0; m_flip = 0;
    m_next = 0; m_cnt = 0; e_wen = 0; e_row = 0; e_col = 0; e_data = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".wen"}, mem_wen, e_wen);
    chk({tag, ".wrow"}, mem_wrow, e_row);
    chk({tag, ".wcol"}, mem_wcol, e_col);
    chk({tag, ".wdata"}, mem_wdata, e_data);
    chk({tag, ".flip"}, mem_flip, m_flip);
    chk({tag, ".flip_count"}, flip_count, m_cnt % 256);
    chk({tag, ".sync_err"}, sync_err, m_err);
    chk({tag, ".busy"}, busy, m_inframe | m_wait);
  endtask

  // one clock: drive, predict, then compare registered outputs
  task automatic cycle(input bit v, input bit sof, input logic [W-1:0] d,
                       input bit fe, output bit acc);
    int widx;
    @(negedge clk);
    s_valid = v; s_sof = sof; s_data = d; frame_end = fe;
    #1;
    chk("ready", s_ready, !m_wait);
    acc = v && !m_wait;
    e_wen = 0;
    if (m_wait) begin
      if (fe) begin m_flip = !m_flip; m_cnt++; m_wait = 0; end
    end else if (acc) begin
      widx = -1;
      if (sof) begin
        if (m_inframe) m_err = 1;
        widx = 0;
      end else if (m_inframe) begin
        widx = m_next;
      end
      if (widx >= 0) begin
        e_wen = 1; e_row = widx / COLS; e_col = widx % COLS; e_data = d;
        m_inframe = 1; m_next = widx + 1;
        if (widx == NPIX - 1) begin m_inframe = 0; m_wait = 1; end
      end
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, a);
  endtask

  // retries until accepted, with occasional random bubbles before the beat
  task automatic send(input bit sof, input logic [W-1:0] d, input bit fe);
    bit a;
    int tries;
    if ($urandom_range(0, 5) == 0) idle(1);
    a = 0; tries = 0;
    while (!a && tries < 1000) begin
      cycle(1, sof, d, fe, a);
      tries++;
    end
    chk("send_timeout", a, 1'b1);
  endtask

  task automatic send_frame(input bit index_data, input int from, input int to);
    for (int i = from; i <= to; i++)
      send(i == 0, index_data ? W'(i) : W'($urandom), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; s_valid = 0; s_sof = 0; frame_end = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    bit a;
    model_reset();
    do_reset();
    idle(1);

    // full frame, data = index
    send_frame(1, 0, NPIX - 1);
    idle(3);
    cycle(0, 0, '0, 1, a);
    idle(2);
    chk("full.flip", mem_flip, 1'b1);
    chk("full.count", flip_count, 8'd1);

    // backpressure: hold a beat for 500 cycles in WAIT_FLIP
    send_frame(0, 0, NPIX - 1);
    for (int i = 0; i < 500; i++) cycle(1, 0, 24'hABCDEF, 0, a);
    cycle(1, 0, 24'hABCDEF, 1, a);
    cycle(1, 0, 24'hABCDEF, 0, a);
    chk("bp.accepted_once", a, 1'b1);
    idle(2);

    // pre-SOF garbage dropped, then a clean frame
    for (int i = 0; i < 10; i++) send(0, W'($urandom), 0);
    send_frame(0, 0, NPIX - 1);
    idle(1);
    cycle(0, 0, '0, 1, a);
    idle(1);

    // mid-frame resync at beat 100
    send_frame(0, 0, 99);
    send(1, W'($urandom), 0);
    chk("resync.err", sync_err, 1'b1);
    send_frame(0, 1, NPIX - 1);
    cycle(0, 0, '0, 1, a);
    idle(1);

    // frame_end coincident with last accept is ignored
    send_frame(0, 0, NPIX - 2);
    send(0, W'($urandom), 1);
    idle(50);
    chk("coinc.noflip_count", flip_count, 8'd4);
    cycle(0, 0, '0, 1, a);
    idle(1);
    chk("coinc.count", flip_count, 8'd5);
    chk("coinc.flip", mem_flip, 1'b1);

    // reset mid-frame, then a stray non-SOF beat is dropped
    send_frame(0, 0, 39);
    do_reset();
    send(0, W'($urandom), 0);
    idle(2);
    chk("rst.idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
